rv32i_mc_control_unit: RTL and testbench

//  Multi-cycle sequencer for the RV32I datapath. Decodes instrCode and drives the

---
 rtl/rv32i_mc_control_unit.sv | 185 ++++++++++++++++++
 tb/tb_rv32i_mc_control_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_control_unit.sv
// Multi-cycle control sequencer for the RV32I datapath.
// The ALU and mux selects are decoded combinationally from instrCode in every state.
// Write-back, PC load, PC-source and bus controls are driven only in the final cycle
// of an instruction or while a bus transaction is in progress.
// Loads and stores use a busReq/busReady handshake. The handshake aborts after
// BUS_TIMEOUT cycles without a ready.
module rv32i_mc_control_unit #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
    input  logic        busReady,
    output logic        regFileWe,
    output logic        aluSrcMuxSel,
    output logic [3:0]  aluControl,
    output logic [2:0]  RFWDSrcMuxSel,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic        pcEn,
    output logic        busReq,
    output logic        busWe,
    output logic [1:0]  busSize,
    output logic        illegalInstr,
    output logic        busError
);

    localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [3:0] {
        FETCH, DECODE, R_EXE, I_EXE, LU_EXE, AU_EXE, B_EXE,
        J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, ILLEGAL
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       mem_timeout;
    logic       unused_instr_bits;

    assign opcode            = instrCode[6:0];
    assign funct3            = instrCode[14:12];
    assign funct7_5          = instrCode[30];
    assign busSize           = instrCode[13:12];
    assign mem_timeout       = (cnt_q == CNT_W'(BUS_TIMEOUT - 1));
    assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

    // Combinational datapath decode, independent of the sequencer state.
    always_comb begin
        aluControl    = 4'b0000;
        aluSrcMuxSel  = 1'b0;
        RFWDSrcMuxSel = 3'd0;
        unique case (opcode)
            OP_R:     aluControl = {funct7_5, funct3};
            OP_I: begin
                aluControl   = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
                aluSrcMuxSel = 1'b1;
            end
            OP_B:     aluControl = {1'b0, funct3};
            OP_L: begin
                aluSrcMuxSel  = 1'b1;
                RFWDSrcMuxSel = 3'd1;
            end
            OP_S:     aluSrcMuxSel = 1'b1;
            OP_LUI:   RFWDSrcMuxSel = 3'd2;
            OP_AUIPC: RFWDSrcMuxSel = 3'd3;
            OP_JAL:   RFWDSrcMuxSel = 3'd4;
            OP_JALR: begin
                aluSrcMuxSel  = 1'b1;
                RFWDSrcMuxSel = 3'd4;
            end
            default: ;
        endcase
    end

    // State and bus-timeout counter registers; asynchronous reset returns to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state selection and state-gated control outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        regFileWe    = 1'b0;
        pcEn         = 1'b0;
        branch       = 1'b0;
        jal          = 1'b0;
        jalr         = 1'b0;
        busReq       = 1'b0;
        busWe        = 1'b0;
        illegalInstr = 1'b0;
        busError     = 1'b0;
        unique case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                unique case (opcode)
                    OP_R:     state_d = R_EXE;
                    OP_I:     state_d = I_EXE;
                    OP_L:     state_d = L_EXE;
                    OP_S:     state_d = S_EXE;
                    OP_B:     state_d = B_EXE;
                    OP_LUI:   state_d = LU_EXE;
                    OP_AUIPC: state_d = AU_EXE;
                    OP_JAL:   state_d = J_EXE;
                    OP_JALR:  state_d = JL_EXE;
                    default:  state_d = ILLEGAL;
                endcase
            end
            R_EXE, I_EXE, LU_EXE, AU_EXE: begin
                regFileWe = 1'b1;
                pcEn      = 1'b1;
                state_d   = FETCH;
            end
            B_EXE: begin
                branch  = 1'b1;
                pcEn    = 1'b1;
                state_d = FETCH;
            end
            J_EXE: begin
                jal       = 1'b1;
                regFileWe = 1'b1;
                pcEn      = 1'b1;
                state_d   = FETCH;
            end
            JL_EXE: begin
                jalr      = 1'b1;
                regFileWe = 1'b1;
                pcEn      = 1'b1;
                state_d   = FETCH;
            end
            S_EXE: begin
                cnt_d   = '0;
                state_d = S_MEM;
            end
            L_EXE: begin
                cnt_d   = '0;
                state_d = L_MEM;
            end
            S_MEM, L_MEM: begin
                busReq = 1'b1;
                busWe  = (state_q == S_MEM);
                if (busReady) begin
                    // A ready in the final timeout cycle still completes normally.
                    pcEn      = 1'b1;
                    regFileWe = (state_q == L_MEM);
                    state_d   = FETCH;
                end else if (mem_timeout) begin
                    busError = 1'b1;
                    pcEn     = 1'b1;
                    state_d  = FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ILLEGAL: begin
                illegalInstr = 1'b1;
                pcEn         = 1'b1;
                state_d      = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_rv32i_mc_control_unit.sv
// Directed bench for the RV32I multi-cycle control sequencer.
// Each cycle pushes the expected control word onto a scoreboard queue.
// The bench then pops that entry and compares it with the DUT outputs.
module tb_rv32i_mc_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrCode;
    logic        busReady;
    logic        regFileWe, aluSrcMuxSel, branch, jal, jalr, pcEn;
    logic        busReq, busWe, illegalInstr, busError;
    logic [3:0]  aluControl;
    logic [2:0]  RFWDSrcMuxSel;
    logic [1:0]  busSize;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [18:0] exp;
    } exp_t;
    exp_t sb[$];

    // Gated output word: {regFileWe,pcEn,branch,jal,jalr,busReq,busWe,illegalInstr,busError}
    localparam logic [8:0] G_NONE  = 9'b000000000;
    localparam logic [8:0] G_WB    = 9'b110000000;
    localparam logic [8:0] G_BR    = 9'b011000000;
    localparam logic [8:0] G_JAL   = 9'b110100000;
    localparam logic [8:0] G_JALR  = 9'b110010000;
    localparam logic [8:0] G_ILL   = 9'b010000010;
    localparam logic [8:0] G_LREQ  = 9'b000001000;
    localparam logic [8:0] G_LDONE = 9'b110001000;
    localparam logic [8:0] G_SREQ  = 9'b000001100;
    localparam logic [8:0] G_SDONE = 9'b010001100;
    localparam logic [8:0] G_SERR  = 9'b010001101;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SRAI  = 32'h40115093;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_LW    = 32'h00012083;
    localparam logic [31:0] I_SW    = 32'h00112023;
    localparam logic [31:0] I_ILL   = 32'h0000007F;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_LUI   = 32'h000010B7;
    localparam logic [31:0] I_AUIPC = 32'h00001097;

    rv32i_mc_control_unit #(.BUS_TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .instrCode    (instrCode),
        .busReady     (busReady),
        .regFileWe    (regFileWe),
        .aluSrcMuxSel (aluSrcMuxSel),
        .aluControl   (aluControl),
        .RFWDSrcMuxSel(RFWDSrcMuxSel),
        .branch       (branch),
        .jal          (jal),
        .jalr         (jalr),
        .pcEn         (pcEn),
        .busReq       (busReq),
        .busWe        (busWe),
        .busSize      (busSize),
        .illegalInstr (illegalInstr),
        .busError     (busError)
    );

    always #5 clk = ~clk;

    // Reference decode: {aluSrcMuxSel, aluControl[3:0], RFWDSrcMuxSel[2:0], busSize[1:0]}
    function automatic logic [9:0] ref_decode(input logic [31:0] ins);
        logic       src;
        logic [3:0] alu;
        logic [2:0] wd;
        src = 1'b0;
        alu = 4'd0;
        wd  = 3'd0;
        case (ins[6:0])
            7'b0110011: alu = {ins[30], ins[14:12]};
            7'b0010011: begin
                src = 1'b1;
                alu = {(ins[14:12] == 3'b101) && ins[30], ins[14:12]};
            end
            7'b1100011: alu = {1'b0, ins[14:12]};
            7'b0000011: begin src = 1'b1; wd = 3'd1; end
            7'b0100011: src = 1'b1;
            7'b0110111: wd = 3'd2;
            7'b0010111: wd = 3'd3;
            7'b1101111: wd = 3'd4;
            7'b1100111: begin src = 1'b1; wd = 3'd4; end
            default: ;
        endcase
        return {src, alu, wd, ins[13:12]};
    endfunction

    // One cycle: drive busReady, queue the expectation, then compare once the outputs settle.
    task automatic cyc(input string tag, input logic [8:0] g, input logic rdy);
        exp_t        e;
        logic [18:0] obs;
        busReady = rdy;
        sb.push_back('{tag, {ref_decode(instrCode), g}});
        #1;
        e   = sb.pop_front();
        obs = {aluSrcMuxSel, aluControl, RFWDSrcMuxSel, busSize,
               regFileWe, pcEn, branch, jal, jalr, busReq, busWe, illegalInstr, busError};
        tests++;
        assert (obs === e.exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
        end
        @(negedge clk);
    endtask

    // Runs a single-execute-cycle instruction through FETCH, DECODE and the final cycle.
    task automatic simple_instr(input string tag, input logic [31:0] ins, input logic [8:0] g);
        instrCode = ins;
        cyc({tag, "_fetch"}, G_NONE, 1'b1);
        cyc({tag, "_decode"}, G_NONE, 1'b1);
        cyc({tag, "_exe"}, g, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        instrCode = I_ADD;
        busReady  = 1'b0;
        @(negedge clk);
        cyc("reset_a", G_NONE, 1'b0);
        cyc("reset_b", G_NONE, 1'b1);
        reset = 1'b0;

        simple_instr("add",   I_ADD,   G_WB);
        simple_instr("srai",  I_SRAI,  G_WB);
        simple_instr("bne",   I_BNE,   G_BR);
        simple_instr("ill",   I_ILL,   G_ILL);
        simple_instr("jal",   I_JAL,   G_JAL);
        simple_instr("jalr",  I_JALR,  G_JALR);
        simple_instr("lui",   I_LUI,   G_WB);
        simple_instr("auipc", I_AUIPC, G_WB);

        // Load: ready held low for two MEM cycles.
        instrCode = I_LW;
        cyc("lw_fetch",  G_NONE, 1'b0);
        cyc("lw_decode", G_NONE, 1'b0);
        cyc("lw_exe",    G_NONE, 1'b1);
        cyc("lw_mem1",   G_LREQ, 1'b0);
        cyc("lw_mem2",   G_LREQ, 1'b0);
        cyc("lw_mem3",   G_LDONE, 1'b1);

        // Store that completes in the first MEM cycle.
        instrCode = I_SW;
        cyc("sw_fetch",  G_NONE, 1'b0);
        cyc("sw_decode", G_NONE, 1'b0);
        cyc("sw_exe",    G_NONE, 1'b0);
        cyc("sw_mem1",   G_SDONE, 1'b1);

        // Store that never sees ready: abort on the 16th MEM cycle.
        cyc("swto_fetch",  G_NONE, 1'b0);
        cyc("swto_decode", G_NONE, 1'b0);
        cyc("swto_exe",    G_NONE, 1'b0);
        for (int i = 1; i < 16; i++) cyc($sformatf("swto_mem%0d", i), G_SREQ, 1'b0);
        cyc("swto_abort", G_SERR, 1'b0);

        // Store where ready arrives exactly in the timeout cycle: normal completion.
        cyc("swlate_fetch",  G_NONE, 1'b0);
        cyc("swlate_decode", G_NONE, 1'b0);
        cyc("swlate_exe",    G_NONE, 1'b0);
        for (int i = 1; i < 16; i++) cyc($sformatf("swlate_mem%0d", i), G_SREQ, 1'b0);
        cyc("swlate_done", G_SDONE, 1'b1);

        // The timeout counter restarts for the next transaction.
        instrCode = I_LW;
        cyc("lw2_fetch",  G_NONE, 1'b0);
        cyc("lw2_decode", G_NONE, 1'b0);
        cyc("lw2_exe",    G_NONE, 1'b0);
        cyc("lw2_mem1",   G_LREQ, 1'b0);
        cyc("lw2_mem2",   G_LDONE, 1'b1);

        // Reset asserted during an L_MEM wait drops busReq without waiting for a clock.
        cyc("lwr_fetch",  G_NONE, 1'b0);
        cyc("lwr_decode", G_NONE, 1'b0);
        cyc("lwr_exe",    G_NONE, 1'b0);
        cyc("lwr_mem1",   G_LREQ, 1'b0);
        reset = 1'b1;
        cyc("lwr_in_reset", G_NONE, 1'b1);
        reset = 1'b0;
        simple_instr("add_after_reset", I_ADD, G_WB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
